// File: rtl/muldiv_unit.sv
// Iterative multiply/divide engine for the E stage: MULT/MULTU/DIV/DIVU into HI/LO.
// Define MULDIV_FASTMUL_EN to replace the 32-cycle shift-add multiply with a single-cycle array product.
module muldiv_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        startE,
    input  logic [1:0]  opE,
    input  logic [31:0] srcaE,
    input  logic [31:0] srcbE,
    input  logic        cancelE,
    output logic        isMulOrDivComputingE,
    output logic        resultReadyE,
    output logic [31:0] hiE,
    output logic [31:0] loE
);
    localparam int DIV_ITERS = 32;
    localparam logic [4:0] LAST = 5'(DIV_ITERS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} stateT;

    stateT       state;
    logic        isDiv, qSign, rSign;
    logic [4:0]  cnt;
    logic [31:0] accHi, accLo, opnd;

    // Launch-side sign handling; unsigned ops (opE[0]) never see a sign
    logic        sa, sb;
    logic [31:0] absA, absB;
    assign sa   = ~opE[0] & srcaE[31];
    assign sb   = ~opE[0] & srcbE[31];
    assign absA = sa ? -srcaE : srcaE;
    assign absB = sb ? -srcbE : srcbE;

    assign isMulOrDivComputingE = ~rst & ~cancelE &
                                  (((state == IDLE) & startE) | (state == RUN));

    // One iteration: divide keeps remainder in accHi and shifts quotient bits into accLo;
    // multiply keeps the upper product in accHi and retires multiplier bits out of accLo.
    logic [32:0] rShift, sum;
    logic        geq;
    logic [31:0] stepHi, stepLo;
    assign rShift = {accHi, accLo[31]};
    assign geq    = rShift >= {1'b0, opnd};
    assign sum    = {1'b0, accHi} + (accLo[0] ? {1'b0, opnd} : 33'd0);

    always_comb begin
        stepHi = '0;
        stepLo = '0;
        if (isDiv) begin
            stepHi = geq ? (rShift[31:0] - opnd) : rShift[31:0];
            stepLo = {accLo[30:0], geq};
        end else begin
            stepHi = sum[32:1];
            stepLo = {sum[0], accLo[31:1]};
        end
    end

    // Sign fix-up. Divide by zero leaves |dividend| as remainder, so rSign restores the dividend.
    logic [63:0] prod, prodFix;
    logic [31:0] quot, rem, finHi, finLo;
    assign prod    = {stepHi, stepLo};
    assign prodFix = qSign ? -prod : prod;
    assign quot    = qSign ? -stepLo : stepLo;
    assign rem     = rSign ? -stepHi : stepHi;

    always_comb begin
        finHi = prodFix[63:32];
        finLo = prodFix[31:0];
        if (isDiv) begin
            finHi = rem;
            finLo = (opnd == 32'd0) ? 32'hFFFF_FFFF : quot;
        end
    end

`ifdef MULDIV_FASTMUL_EN
    logic [63:0] fastProd, fastFix;
    assign fastProd = 64'(absA) * 64'(absB);
    assign fastFix  = (sa ^ sb) ? -fastProd : fastProd;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            isDiv        <= 1'b0;
            qSign        <= 1'b0;
            rSign        <= 1'b0;
            cnt          <= '0;
            accHi        <= '0;
            accLo        <= '0;
            opnd         <= '0;
            hiE          <= '0;
            loE          <= '0;
            resultReadyE <= 1'b0;
        end else begin
            resultReadyE <= 1'b0;
            if (cancelE) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: if (startE) begin
                        isDiv <= opE[1];
                        qSign <= sa ^ sb;
                        rSign <= sa;
                        cnt   <= '0;
                        accHi <= '0;
                        accLo <= opE[1] ? absA : absB;
                        opnd  <= opE[1] ? absB : absA;
                        state <= RUN;
`ifdef MULDIV_FASTMUL_EN
                        if (!opE[1]) begin
                            hiE          <= fastFix[63:32];
                            loE          <= fastFix[31:0];
                            resultReadyE <= 1'b1;
                            state        <= DONE;
                        end
`endif
                    end
                    RUN: begin
                        accHi <= stepHi;
                        accLo <= stepLo;
                        cnt   <= cnt + 5'd1;
                        if (cnt == LAST) begin
                            hiE          <= finHi;
                            loE          <= finLo;
                            resultReadyE <= 1'b1;
                            state        <= DONE;
                        end
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: behavioural HI/LO model feeds a scoreboard queue checked on each pulse.
module tb_muldiv_unit;
    logic        clk, rst, startE, cancelE;
    logic [1:0]  opE;
    logic [31:0] srcaE, srcbE;
    logic        isMulOrDivComputingE, resultReadyE;
    logic [31:0] hiE, loE;

    int checks = 0;
    int failures = 0;
    int pulses = 0;
    logic [63:0] expQ[$];
    logic [63:0] lastExp = '0;

    muldiv_unit dut (
        .clk(clk), .rst(rst), .startE(startE), .opE(opE), .srcaE(srcaE), .srcbE(srcbE),
        .cancelE(cancelE), .isMulOrDivComputingE(isMulOrDivComputingE),
        .resultReadyE(resultReadyE), .hiE(hiE), .loE(loE)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Independent reference: native 64-bit arithmetic, truncating signed division
    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            2'b00: return 64'(sa * sb);
            2'b01: return 64'(a) * 64'(b);
            2'b10: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {32'(r), 32'(q)};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    function automatic int expLat(input logic [1:0] op);
`ifdef MULDIV_FASTMUL_EN
        if (!op[1]) return 1;
`endif
        return 33;
    endfunction

    // Scoreboard: every pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (resultReadyE) begin
            pulses++;
            if (expQ.size() == 0) begin
                check("unexpected_pulse", 64'(resultReadyE), 64'd0);
            end else begin
                logic [63:0] e;
                e = expQ.pop_front();
                check("hiE", 64'(hiE), 64'(e[63:32]));
                check("loE", 64'(loE), 64'(e[31:0]));
            end
        end
    end

    // Starts an op in the cycle after the next edge and holds startE through DONE
    task automatic runOp(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        int lat, busyN;
        bit got;
        @(posedge clk); #1;
        startE = 1'b1; opE = op; srcaE = a; srcbE = b;
        lastExp = model(op, a, b);
        expQ.push_back(lastExp);
        lat = -1; busyN = 0; got = 1'b0;
        while (!got && lat < 100) begin
            @(negedge clk);
            lat++;
            if (resultReadyE) got = 1'b1;
            else if (isMulOrDivComputingE) busyN++;
        end
        check({tag, "_pulse"}, 64'(got), 64'd1);
        check({tag, "_latency"}, 64'(lat), 64'(expLat(op)));
        check({tag, "_busyCycles"}, 64'(busyN), 64'(expLat(op)));
        check({tag, "_busyAtDone"}, 64'(isMulOrDivComputingE), 64'd0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            startE = 1'b0; cancelE = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        rst = 1'b1; startE = 1'b1; cancelE = 1'b0; opE = 2'b00; srcaE = '0; srcbE = '0;
        #12;
        check("rst_busy", 64'(isMulOrDivComputingE), 64'd0);
        check("rst_ready", 64'(resultReadyE), 64'd0);
        check("rst_hi", 64'(hiE), 64'd0);
        check("rst_lo", 64'(loE), 64'd0);
        startE = 1'b0;
        #10 rst = 1'b0;

        runOp("divu_100_7", 2'b11, 32'd100, 32'd7);
        check("divu_100_7_lo_lit", 64'(loE), 64'd14);
        check("divu_100_7_hi_lit", 64'(hiE), 64'd2);
        runOp("div_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2);
        check("div_m7_2_lo_lit", 64'(loE), 64'hFFFF_FFFD);
        check("div_m7_2_hi_lit", 64'(hiE), 64'hFFFF_FFFF);
        runOp("div_5_0", 2'b10, 32'd5, 32'd0);
        runOp("mult_m1_m1", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("mult_m1_m1_lit", {32'(hiE), 32'(loE)}, 64'd1);
        runOp("multu_ff_ff", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("multu_ff_ff_lit", {32'(hiE), 32'(loE)}, 64'hFFFF_FFFE_0000_0001);
        runOp("div_min_m1", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        runOp("divu_9_0", 2'b11, 32'd9, 32'd0);
        runOp("div_m9_0", 2'b10, 32'hFFFF_FFF7, 32'd0);
        runOp("mult_m3_5", 2'b00, 32'hFFFF_FFFD, 32'd5);
        runOp("div_7_m2", 2'b10, 32'd7, 32'hFFFF_FFFE);
        runOp("multu_mix", 2'b01, 32'h1234_5678, 32'h9ABC_DEF0);
        idle(2);

        // Cancel at C+10 of a DIV
        @(posedge clk); #1;
        startE = 1'b1; opE = 2'b10; srcaE = 32'd1000; srcbE = 32'd3;
        repeat (10) @(posedge clk);
        #1 cancelE = 1'b1;
        @(negedge clk);
        check("cancel_busy", 64'(isMulOrDivComputingE), 64'd0);
        @(posedge clk); #1;
        cancelE = 1'b0; startE = 1'b0;
        @(negedge clk);
        check("cancel_idle_busy", 64'(isMulOrDivComputingE), 64'd0);
        p0 = pulses;
        repeat (40) @(negedge clk);
        check("cancel_no_pulse", 64'(pulses), 64'(p0));
        check("cancel_hold_hilo", {32'(hiE), 32'(loE)}, lastExp);
        runOp("divu_after_cancel", 2'b11, 32'd50, 32'd6);
        idle(2);

        // Asynchronous reset mid-RUN
        @(posedge clk); #1;
        startE = 1'b1; opE = 2'b11; srcaE = 32'd1000; srcbE = 32'd3;
        repeat (5) @(posedge clk);
        #3 rst = 1'b1; startE = 1'b0;
        #1;
        check("arst_hi", 64'(hiE), 64'd0);
        check("arst_lo", 64'(loE), 64'd0);
        check("arst_busy", 64'(isMulOrDivComputingE), 64'd0);
        check("arst_ready", 64'(resultReadyE), 64'd0);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        check("arst_idle_busy", 64'(isMulOrDivComputingE), 64'd0);
        runOp("div_after_rst", 2'b10, 32'hFFFF_FF9C, 32'd7);
        idle(3);
        check("queue_drained", 64'(expQ.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Multi-cycle multiply/divide engine in the Execute stage of the 5-stage MIPS pipeline. It computes 64-bit HI/LO results for MULT, MULTU, DIV and DIVU. While an operation is in flight it drives the hazard unit's `isMulOrDivComputingE` input, which freezes F through W. It releases the pipeline in the cycle the result is presented, and the HI/LO write-back logic consumes that result.

## Interface
Parameters:
- `DIV_ITERS`, default 32: divide iteration count; fixed for 32-bit operands; not overridable.

Ports:
- `clk` in 1: pipeline clock.
- `rst` in 1: asynchronous, active-high reset.
- `startE` in 1: the instruction in E is a mult/div; level signal, held while E is stalled.
- `opE` in 2: operation select. 00 = MULT, 01 = MULTU, 10 = DIV, 11 = DIVU.
- `srcaE` in 32: rs operand (multiplicand / dividend).
- `srcbE` in 32: rt operand (multiplier / divisor).
- `cancelE` in 1: abort, used for an exception or flush of E.
- `isMulOrDivComputingE` out 1: busy, routed to the hazard unit stall input.
- `resultReadyE` out 1: one-cycle pulse; `hiE`/`loE` are newly valid in that cycle.
- `hiE` out 32: high word for multiply, remainder for divide.
- `loE` out 32: low word for multiply, quotient for divide.

## Operation
- States: IDLE, RUN, DONE. Reset puts the unit in IDLE.
- Reset values: `hiE` = 0, `loE` = 0, `resultReadyE` = 0, counter = 0. `isMulOrDivComputingE` is forced to 0 while `rst` is high.
- IDLE:
  - `isMulOrDivComputingE = startE & ~cancelE` (combinational).
  - On `startE & ~cancelE`, latch the following and go to RUN:
    - `opE`;
    - the absolute values of the operands (signed ops only);
    - the result sign, qsign = sa^sb and rsign = sa;
    - counter = 0.
- RUN:
  - `isMulOrDivComputingE` = 1.
  - Divide: radix-2 restoring, one quotient bit per cycle on a 33-bit partial remainder.
  - Multiply (iterative): shift-add, one multiplier bit per cycle into a 64-bit accumulator.
  - After the last iteration (counter = 31), apply sign fix-up and register the result into `hiE`/`loE`. Go to DONE.
- DONE:
  - `isMulOrDivComputingE` = 0 and `resultReadyE` = 1.
  - `startE` is ignored, because the same instruction is still in E. This prevents a re-launch.
  - Next cycle: go to IDLE.
- Signed results:
  - Multiply: negate the 64-bit product if the signs differ.
  - Divide: negate the quotient if qsign; negate the remainder if rsign.
- Boundary cases:
  - Divide by zero: `loE` = 32'hFFFF_FFFF and `hiE` = dividend, for both signed and unsigned.
  - Signed 0x8000_0000 / -1: `loE` = 0x8000_0000, `hiE` = 0. No trap.
- `cancelE`:
  - Highest priority, in any state.
  - `isMulOrDivComputingE` = 0 in that cycle and the unit goes to IDLE next cycle.
  - `hiE`/`loE` are not updated and `resultReadyE` is not pulsed.
- Back-to-back operations: a new `startE` is accepted in the IDLE cycle that follows DONE.

## Timing
- Let cycle C be the one in which `startE` is seen in IDLE.
- Divide: busy in C..C+32 (33 cycles). DONE, result and pulse in C+33.
- Iterative multiply: same timing as divide.
- Fast multiply (see Configuration): busy in C only. DONE in C+1.
- `hiE`/`loE` change only on the clock edge entering DONE. They hold until the next completion.
- Asynchronous reset mid-RUN: the unit returns to IDLE at once and outputs take their reset values. No partial result is written.

## Configuration
- Macro: `MULDIV_FASTMUL_EN`.
- Defined:
  - Multiply uses a single-cycle 32x32 array product, registered on the edge C→C+1.
  - RUN is skipped for multiply: IDLE→DONE.
  - Divide is unchanged.
- Undefined:
  - Multiply uses the 32-cycle shift-add datapath and has the same timing as divide.
  - No hardware multiplier is inferred.

## Test plan
1. DIVU, srca = 100, srcb = 7 → busy for 33 cycles from C; in C+33 `loE` = 14, `hiE` = 2, `resultReadyE` = 1; busy = 0.
2. DIV, srca = -7 (0xFFFF_FFF9), srcb = 2 → `loE` = 0xFFFF_FFFD (-3), `hiE` = 0xFFFF_FFFF (-1). Also: DIV with srcb = 0 and srca = 5 → `loE` = 0xFFFF_FFFF, `hiE` = 5.
3. MULT, 0xFFFF_FFFF × 0xFFFF_FFFF → `hiE` = 0, `loE` = 1. MULTU with the same operands → `hiE` = 0xFFFF_FFFE, `loE` = 1. Check the latency for both macro settings: 1 busy cycle with the macro, 33 without.
4. `startE` held high through DONE → exactly one `resultReadyE` pulse and no re-launch. Then a new DIVU is started in the next cycle and is accepted.
5. `cancelE` asserted in C+10 of a DIV → busy drops in that cycle and the unit is in IDLE next cycle. `hiE`/`loE` keep their previous values and no pulse is produced.
6. `rst` asserted asynchronously mid-RUN → state returns to IDLE and `hiE`/`loE` = 0 immediately. After release, the next operation runs normally.
